// File: rtl/core_dump_if.sv
// core_dump_if: dump beat stream (valid/ready) from core_dump_monitor to a trace sink
//  out_valid  beat valid (master -> slave)
//  out_ready  sink accepts beat (slave -> master)
//  out_idx    register index of beat
//  out_data   register value of beat
//  out_bp     breakpoint that caused the dump
interface core_dump_if #(parameter int XLEN = 32);
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_idx;
    logic [XLEN-1:0] out_data;
    logic [2:0]      out_bp;
    modport master (output out_valid, out_idx, out_data, out_bp, input out_ready);
    modport slave  (input out_valid, out_idx, out_data, out_bp, output out_ready);
endinterface

// File: rtl/core_dump_monitor.sv
// core_dump_monitor: breakpoint-triggered register-file dump streamer with cycle budget
//  clk, rst   clock, synchronous active-high reset
//  en         monitor enable (low forces IDLE, aborting any dump)
//  bp_en      per-breakpoint enable; bp_pc packs breakpoint pcs
//  pc, state  core pc and state; pc is compared only when state == FETCH_ST
//  regs       core register file, snapshotted on a hit
//  dump       beat stream (master side)
//  hit_cnt    dumps started; drop_cnt hits seen while dumping (both saturating)
//  cycle_cnt  enabled cycles since reset (saturating); done sticky when budget is spent
module core_dump_monitor #(
    parameter int         XLEN     = 32,
    parameter int         NREGS    = 32,
    parameter int         NBP      = 4,
    parameter logic [1:0] FETCH_ST = 2'd0,
    parameter int         CYC_W    = 32,
    parameter int         TIMEOUT  = 60930
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NBP-1:0]        bp_en,
    input  logic [NBP*XLEN-1:0]   bp_pc,
    input  logic [XLEN-1:0]       pc,
    input  logic [1:0]            state,
    input  logic [NREGS*XLEN-1:0] regs,
    core_dump_if.master           dump,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           drop_cnt,
    output logic [CYC_W-1:0]      cycle_cnt,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, ARMED, DUMP, FIN} fsm_t;
    fsm_t            fsm;
    logic [XLEN-1:0] snap [NREGS];
    logic            match, cond, hit, inc, expire, fin;
    logic [2:0]      bpi;
    // Descending scan so the lowest matching breakpoint is the one left in bpi.
    always_comb begin
        match = 1'b0;
        bpi = '0;
        for (int i = NBP - 1; i >= 0; i--)
            if (bp_en[i] && pc == bp_pc[i*XLEN +: XLEN]) begin
                match = 1'b1;
                bpi = 3'(i);
            end
    end
    assign cond   = state == FETCH_ST && match;
    assign hit    = en && fsm == ARMED && cond;
    assign inc    = en && !done;
    assign expire = TIMEOUT != 0 && inc && cycle_cnt == CYC_W'(TIMEOUT - 1);
    // Budget spent now or already: no new dump may start after this point.
    assign fin    = done || expire;
    always_ff @(posedge clk)
        if (hit)
            for (int r = 0; r < NREGS; r++) snap[r] <= regs[r*XLEN +: XLEN];
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
            dump.out_valid <= 1'b0;
            dump.out_idx <= '0;
            dump.out_data <= '0;
            dump.out_bp <= '0;
            hit_cnt <= '0;
            drop_cnt <= '0;
            cycle_cnt <= '0;
            done <= 1'b0;
        end else begin
            if (inc && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + CYC_W'(1);
            if (expire) done <= 1'b1;
            if (hit && !(&hit_cnt)) hit_cnt <= hit_cnt + 16'd1;
            if (fsm == DUMP && cond && !(&drop_cnt)) drop_cnt <= drop_cnt + 16'd1;
            case (fsm)
                IDLE:  if (en) fsm <= fin ? FIN : ARMED;
                ARMED:
                    if (hit) begin
                        fsm <= DUMP;
                        dump.out_valid <= 1'b1;
                        dump.out_idx <= '0;
                        dump.out_data <= regs[XLEN-1:0];
                        dump.out_bp <= bpi;
                    end else if (fin) fsm <= FIN;
                DUMP:
                    if (dump.out_ready) begin
                        if (dump.out_idx == 5'(NREGS - 1)) begin
                            dump.out_valid <= 1'b0;
                            fsm <= fin ? FIN : ARMED;
                        end else begin
                            dump.out_idx <= dump.out_idx + 5'd1;
                            dump.out_data <= snap[dump.out_idx + 5'd1];
                        end
                    end
                default: ;
            endcase
            // Disable wins over every transition except the sticky budget stop.
            if (!en && fsm != FIN) begin
                fsm <= IDLE;
                dump.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_core_dump_monitor.sv
// tb_core_dump_monitor: directed checks of dump streaming, priority, stalls, drops, abort and budget
module tb_core_dump_monitor;
    logic          clk = 1'b0;
    logic          rst, en, en1;
    logic [3:0]    bp_en, bp_en1;
    logic [127:0]  bp_pc;
    logic [31:0]   pc;
    logic [1:0]    state;
    logic [1023:0] regs;
    logic [15:0]   hit_cnt, drop_cnt, hit_cnt1, drop_cnt1;
    logic [31:0]   cycle_cnt, cycle_cnt1;
    logic          done, done1;
    int            n = 0;
    int            fails = 0;
    int            beats;
    core_dump_if #(.XLEN(32)) if0 ();
    core_dump_if #(.XLEN(32)) if1 ();
    core_dump_monitor u0 (
        .clk(clk), .rst(rst), .en(en), .bp_en(bp_en), .bp_pc(bp_pc), .pc(pc), .state(state),
        .regs(regs), .dump(if0), .hit_cnt(hit_cnt), .drop_cnt(drop_cnt),
        .cycle_cnt(cycle_cnt), .done(done)
    );
    core_dump_monitor #(.TIMEOUT(100)) u1 (
        .clk(clk), .rst(rst), .en(en1), .bp_en(bp_en1), .bp_pc(bp_pc), .pc(pc), .state(state),
        .regs(regs), .dump(if1), .hit_cnt(hit_cnt1), .drop_cnt(drop_cnt1),
        .cycle_cnt(cycle_cnt1), .done(done1)
    );
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic hit_at(input logic [31:0] p);
        state = 2'd0;
        pc = p;
        step();
        state = 2'd1;
        pc = 32'd0;
    endtask
    task automatic drain;
        for (int t = 0; t < 40 && if0.out_valid; t++) step();
        chk("drain_valid", 64'(if0.out_valid), 64'd0);
    endtask
    task automatic set_regs(input int mul, input int add);
        for (int r = 0; r < 32; r++) regs[r*32 +: 32] = 32'(r * mul + add);
    endtask
    initial begin
        rst = 1'b1; en = 1'b0; en1 = 1'b0; bp_en = '0; bp_en1 = '0; bp_pc = '0;
        pc = '0; state = 2'd1; regs = '0; if0.out_ready = 1'b1; if1.out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(if0.out_valid), 64'd0);
        chk("rst_idx", 64'(if0.out_idx), 64'd0);
        chk("rst_data", 64'(if0.out_data), 64'd0);
        chk("rst_bp", 64'(if0.out_bp), 64'd0);
        chk("rst_hit", 64'(hit_cnt), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_cyc", 64'(cycle_cnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_done1", 64'(done1), 64'd0);
        // 1: basic dump of regs[r] = 3r
        rst = 1'b0; en = 1'b1; bp_en = 4'b0001; bp_pc[0 +: 32] = 32'd35;
        set_regs(3, 0);
        step();
        chk("t1_idle_valid", 64'(if0.out_valid), 64'd0);
        hit_at(32'd35);
        chk("t1_bp", 64'(if0.out_bp), 64'd0);
        chk("t1_hit", 64'(hit_cnt), 64'd1);
        for (int k = 0; k < 32; k++) begin
            chk("t1_valid", 64'(if0.out_valid), 64'd1);
            chk("t1_idx", 64'(if0.out_idx), 64'(k));
            chk("t1_data", 64'(if0.out_data), 64'(k * 3));
            step();
        end
        chk("t1_end_valid", 64'(if0.out_valid), 64'd0);
        chk("t1_drop", 64'(drop_cnt), 64'd0);
        // 2: lowest enabled breakpoint wins
        bp_pc[64 +: 32] = 32'd35; bp_en = 4'b0101;
        hit_at(32'd35);
        chk("t2_bp0", 64'(if0.out_bp), 64'd0);
        chk("t2_hit", 64'(hit_cnt), 64'd2);
        drain();
        bp_en = 4'b0100;
        hit_at(32'd35);
        chk("t2_bp2", 64'(if0.out_bp), 64'd2);
        chk("t2_valid", 64'(if0.out_valid), 64'd1);
        drain();
        // 3: stalls every other cycle, regs rewritten after the hit
        bp_en = 4'b0001;
        hit_at(32'd35);
        set_regs(7, 1);
        beats = 0;
        for (int t = 0; t < 200 && if0.out_valid; t++) begin
            chk("t3_idx", 64'(if0.out_idx), 64'(beats));
            chk("t3_data", 64'(if0.out_data), 64'(beats * 3));
            chk("t3_bp", 64'(if0.out_bp), 64'd0);
            if0.out_ready = t[0];
            if (if0.out_ready) beats++;
            step();
        end
        chk("t3_beats", 64'(beats), 64'd32);
        chk("t3_end_valid", 64'(if0.out_valid), 64'd0);
        chk("t3_hit", 64'(hit_cnt), 64'd4);
        if0.out_ready = 1'b1;
        set_regs(3, 0);
        // 4: five hit conditions during a dump are dropped
        hit_at(32'd35);
        for (int t = 0; t < 5; t++) begin
            state = 2'd0;
            pc = 32'd35;
            step();
        end
        state = 2'd1; pc = 32'd0;
        chk("t4_drop", 64'(drop_cnt), 64'd5);
        chk("t4_idx", 64'(if0.out_idx), 64'd5);
        drain();
        step();
        step();
        chk("t4_no_redump", 64'(if0.out_valid), 64'd0);
        chk("t4_hit", 64'(hit_cnt), 64'd5);
        // 6: disable mid-dump, then fresh dump from idx 0
        hit_at(32'd35);
        for (int t = 0; t < 7; t++) step();
        chk("t6_idx7", 64'(if0.out_idx), 64'd7);
        chk("t6_valid7", 64'(if0.out_valid), 64'd1);
        en = 1'b0;
        step();
        chk("t6_abort", 64'(if0.out_valid), 64'd0);
        en = 1'b1;
        step();
        hit_at(32'd35);
        chk("t6_fresh_valid", 64'(if0.out_valid), 64'd1);
        chk("t6_fresh_idx", 64'(if0.out_idx), 64'd0);
        chk("t6_fresh_data", 64'(if0.out_data), 64'd0);
        chk("t6_hit", 64'(hit_cnt), 64'd7);
        drain();
        // 5: budget of 100 cycles on the second monitor
        chk("t5_cyc0", 64'(cycle_cnt1), 64'd0);
        en1 = 1'b1;
        for (int t = 0; t < 99; t++) step();
        chk("t5_cyc99", 64'(cycle_cnt1), 64'd99);
        chk("t5_done99", 64'(done1), 64'd0);
        step();
        chk("t5_cyc100", 64'(cycle_cnt1), 64'd100);
        chk("t5_done100", 64'(done1), 64'd1);
        for (int t = 0; t < 5; t++) step();
        chk("t5_cyc_hold", 64'(cycle_cnt1), 64'd100);
        bp_en1 = 4'b0001;
        state = 2'd0; pc = 32'd35;
        step();
        state = 2'd1; pc = 32'd0;
        step();
        chk("t5_no_dump", 64'(if1.out_valid), 64'd0);
        chk("t5_hit", 64'(hit_cnt1), 64'd0);
        chk("t5_done_sticky", 64'(done1), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
